ps2_key_mapper: RTL

//  Parametrised PS/2 scan-code-set-2 key mapper for N players x 4 directions.

---
 rtl/ps2_pkg.sv | 35 +++
 rtl/ps2_prefix_fsm.sv | 79 +++++++
 rtl/ps2_key_mapper.sv | 95 +++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and byte constants for the PS/2 set-2 key mapper.
// A byte is either a prefix, an error code, an ignored host-protocol code, or a key code.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PFX_EXT     = 8'hE0;
  localparam logic [7:0] PFX_BRK     = 8'hF0;
  localparam logic [7:0] CODE_ERR_LO = 8'h00;
  localparam logic [7:0] CODE_ERR_HI = 8'hFF;
  localparam logic [7:0] CODE_ACK    = 8'hFA;
  localparam logic [7:0] CODE_BAT_OK = 8'hAA;
  localparam logic [7:0] CODE_RESEND = 8'hFE;
  localparam logic [7:0] CODE_ECHO   = 8'hEE;

  // Key index within a player's group of four.
  localparam int DIR_RIGHT = 0;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_UP    = 3;

  function automatic logic is_err_code(input logic [7:0] b);
    return (b == CODE_ERR_LO) || (b == CODE_ERR_HI);
  endfunction

  function automatic logic is_ignored_code(input logic [7:0] b);
    return (b == CODE_ACK) || (b == CODE_BAT_OK) || (b == CODE_RESEND) || (b == CODE_ECHO);
  endfunction

endpackage

// File: rtl/ps2_prefix_fsm.sv
// Turns the raw PS/2 byte stream into make/break events with a 9-bit code (bit8 = E0-extended).
// state      | meaning
// ST_IDLE    | no prefix pending
// ST_EXT     | E0 seen, waiting for code or F0
// ST_BRK     | F0 seen, next byte is a break code
// ST_EXT_BRK | E0 F0 seen, next byte is an extended break code
module ps2_prefix_fsm
  import ps2_pkg::*;
(
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       clear,
  input  logic [7:0] DATA_IN,
  input  logic       DATA_VALID,
  output logic       evt_valid,
  output logic       evt_make,
  output logic [8:0] evt_code,
  output logic       err
);

  ps2_state_e state, state_nxt;

  always_ff @(posedge CLK) begin
    if (!RSTn)
      state <= ST_IDLE;
    else if (clear)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    evt_valid = 1'b0;
    evt_make  = 1'b0;
    evt_code  = {1'b0, DATA_IN};
    err       = 1'b0;
    if (DATA_VALID) begin
      if (is_err_code(DATA_IN)) begin
        err       = 1'b1;
        state_nxt = ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (DATA_IN == PFX_EXT)
              state_nxt = ST_EXT;
            else if (DATA_IN == PFX_BRK)
              state_nxt = ST_BRK;
            else if (!is_ignored_code(DATA_IN)) begin
              evt_valid = 1'b1;
              evt_make  = 1'b1;
            end
          end
          ST_EXT: begin
            if (DATA_IN == PFX_BRK)
              state_nxt = ST_EXT_BRK;
            else if (DATA_IN != PFX_EXT) begin
              evt_valid = 1'b1;
              evt_make  = 1'b1;
              evt_code  = {1'b1, DATA_IN};
              state_nxt = ST_IDLE;
            end
          end
          ST_BRK: begin
            evt_valid = 1'b1;
            state_nxt = ST_IDLE;
          end
          ST_EXT_BRK: begin
            evt_valid = 1'b1;
            evt_code  = {1'b1, DATA_IN};
            state_nxt = ST_IDLE;
          end
          default: state_nxt = ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_key_mapper.sv
// Maps PS/2 make/break events onto N players x 4 direction keys as active-low held levels,
// with a press pulse, an any-key flag, protocol-error flag and an optional idle watchdog.
module ps2_key_mapper
  import ps2_pkg::*;
#(
  parameter int                         NUM_PLAYERS    = 2,
  parameter logic [36*NUM_PLAYERS-1:0]  KEYMAP         = {9'h175, 9'h172, 9'h16B, 9'h174,
                                                          9'h01D, 9'h01B, 9'h01C, 9'h023},
  parameter int                         TIMEOUT_CYCLES = 0
) (
  input  logic                       CLK,
  input  logic                       RSTn,
  input  logic [7:0]                 DATA_IN,
  input  logic                       DATA_VALID,
  output logic [4*NUM_PLAYERS-1:0]   KEY_N,
  output logic [4*NUM_PLAYERS-1:0]   KEY_PULSE,
  output logic                       ANY_KEY,
  output logic                       SEQ_ERR
);

  localparam int NK = 4 * NUM_PLAYERS;

  logic          evt_valid;
  logic          evt_make;
  logic [8:0]    evt_code;
  logic          err;
  logic          expire;
  logic [NK-1:0] key_n_nxt;
  logic [NK-1:0] pulse_nxt;

  ps2_prefix_fsm u_fsm (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .clear      (expire),
    .DATA_IN    (DATA_IN),
    .DATA_VALID (DATA_VALID),
    .evt_valid  (evt_valid),
    .evt_make   (evt_make),
    .evt_code   (evt_code),
    .err        (err)
  );

  // Expiry is only possible on a cycle without a byte, so an arriving byte always wins.
  if (TIMEOUT_CYCLES > 0) begin : g_wdog
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] idle_cnt;

    always_ff @(posedge CLK) begin
      if (!RSTn)
        idle_cnt <= '0;
      else if (DATA_VALID)
        idle_cnt <= '0;
      else if (idle_cnt != CW'(TIMEOUT_CYCLES))
        idle_cnt <= idle_cnt + 1'b1;
    end

    assign expire = !DATA_VALID && (idle_cnt >= CW'(TIMEOUT_CYCLES - 1));
  end else begin : g_no_wdog
    assign expire = 1'b0;
  end

  always_comb begin
    key_n_nxt = KEY_N;
    pulse_nxt = '0;
    if (err || expire) begin
      key_n_nxt = '1;
    end else if (evt_valid) begin
      for (int i = 0; i < NK; i++) begin
        if (evt_code == KEYMAP[9*i+8 -: 9]) begin
          if (!evt_make)
            key_n_nxt[i] = 1'b1;
          else if (KEY_N[i]) begin
            key_n_nxt[i] = 1'b0;
            pulse_nxt[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      KEY_N     <= '1;
      KEY_PULSE <= '0;
      ANY_KEY   <= 1'b0;
      SEQ_ERR   <= 1'b0;
    end else begin
      KEY_N     <= key_n_nxt;
      KEY_PULSE <= pulse_nxt;
      ANY_KEY   <= ~&key_n_nxt;
      SEQ_ERR   <= err;
    end
  end

endmodule
